clk_period_meter: RTL and testbench

Measures the period and high time of a slow square wave, counted in cycles of the system clock. Typical inputs are the output of the clock dividers, or any external periodic signal, for on-board verification of divider ratios and duty cycle. One measurement is taken per `start` request. The result is returned through a valid/ready handshake, and a timeout is reported if the input stops toggling.

---
 rtl/clk_meas_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/clk_period_meter.sv | 106 ++++++++++
 tb/tb_clk_period_meter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared constants for the clock period meter and the divider benches.
// State encoding plus default counter width and timeout.
package clk_meas_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t WAIT_EDGE = 2'd1;
  localparam state_t MEASURE   = 2'd2;
  localparam state_t HOLD      = 2'd3;

  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level input,
// followed by a history flop for rise/fall detection.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign s    = r_sync[SYNC_STAGES-1];
  assign rise = s & ~r_prev;
  assign fall = ~s & r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow input in clk cycles,
// one measurement per start, result returned via valid/ready.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_high_sh;
  logic             r_timeout;
  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_cnt_max;
  logic             w_to;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .s     (w_s),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT_CYC));
  assign w_to      = ((r_state == WAIT_EDGE) || (r_state == MEASURE))
                     && !w_rise && w_cnt_max;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (start) w_next = WAIT_EDGE;
      WAIT_EDGE: begin
        if (w_rise)    w_next = MEASURE;
        else if (w_to) w_next = IDLE;
      end
      MEASURE:   begin
        if (w_rise)    w_next = HOLD;
        else if (w_to) w_next = IDLE;
      end
      HOLD:      if (res_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    res_valid = (r_state == HOLD);
    busy      = (r_state != IDLE);
    timeout   = r_timeout;
    period    = r_period;
    high_time = r_high;
  end

  // High time is staged so an aborted measurement leaves results untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_high_sh <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to;
      unique case (r_state)
        IDLE:      if (start) r_cnt <= CNT_W'(1);
        WAIT_EDGE: r_cnt <= w_rise ? CNT_W'(1) : r_cnt + CNT_W'(1);
        MEASURE:   begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_fall && !w_s) r_high_sh <= r_cnt;
          if (w_rise) begin
            r_period <= r_cnt;
            r_high   <= r_high_sh;
          end
        end
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: divider-like waveforms,
// timeout, stalled handshake, mid-measure reset.
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        start;
  logic        res_ready;
  logic        res_valid;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        timeout;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  int hi_len = 3;
  int lo_len = 3;
  bit gen_en = 1'b0;
  int ph     = 0;

  clk_period_meter #(
    .CNT_W      (32),
    .TIMEOUT_CYC(100),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .start    (start),
    .res_ready(res_ready),
    .res_valid(res_valid),
    .period   (period),
    .high_time(high_time),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Input waveform: hi_len cycles high then lo_len cycles low
  always @(posedge clk) begin
    #2;
    if (!gen_en) begin
      sig_in = 1'b0;
      ph     = 0;
    end else begin
      sig_in = (ph < hi_len);
      ph     = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_wave(input int h, input int l);
    gen_en = 1'b0;
    repeat (6) @(negedge clk);
    hi_len = h;
    lo_len = l;
    gen_en = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    chk({tag, "/valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic do_meas(input string tag,
                         input int exp_p,
                         input int exp_h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/busy1"}, 32'(busy), 32'd1);
    wait_valid(tag);
    chk({tag, "/period"}, period, 32'(exp_p));
    chk({tag, "/high"}, high_time, 32'(exp_h));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "/valid0"}, 32'(res_valid), 32'd0);
    chk({tag, "/busy0"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  first_to;
    int  to_cyc;
    bit  rv_seen;
    bit  stable;

    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    sig_in    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/valid", 32'(res_valid), 32'd0);
    chk("rst/period", period, 32'd0);
    chk("rst/high", high_time, 32'd0);
    chk("rst/timeout", 32'(timeout), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    set_wave(3, 3);
    do_meas("div3", 6, 3);

    set_wave(3, 7);
    for (int k = 0; k < 5; k++)
      do_meas($sformatf("d3_7_%0d", k), 10, 3);

    gen_en = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    first_to = -1;
    to_cyc   = 0;
    rv_seen  = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      if (timeout) begin
        to_cyc++;
        if (first_to < 0) first_to = k - 1;
      end
      if (res_valid) rv_seen = 1'b1;
      @(negedge clk);
    end
    chk("to/when", 32'(first_to), 32'd100);
    chk("to/width", 32'(to_cyc), 32'd1);
    chk("to/no_valid", 32'(rv_seen), 32'd0);
    chk("to/period", period, 32'd10);
    chk("to/high", high_time, 32'd3);
    chk("to/busy", 32'(busy), 32'd0);

    set_wave(4, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("stall");
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      if (!res_valid || period != 32'd6 || high_time != 32'd4)
        stable = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall/stable", 32'(stable), 32'd1);
    chk("stall/period", period, 32'd6);
    chk("stall/high", high_time, 32'd4);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("stall/valid0", 32'(res_valid), 32'd0);
    chk("stall/busy0", 32'(busy), 32'd0);

    set_wave(5, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (sig_in) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("mrst/busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst/valid", 32'(res_valid), 32'd0);
    chk("mrst/period", period, 32'd0);
    chk("mrst/high", high_time, 32'd0);
    chk("mrst/timeout", 32'(timeout), 32'd0);
    chk("mrst/busy", 32'(busy), 32'd0);
    set_wave(2, 2);
    do_meas("p4", 4, 2);

    set_wave(1, 1);
    do_meas("p2", 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
